clz_expand: RTL

- Multi-cycle inverse of the leading-zero counter in the CPU54 datapath.
- Takes a normalized mantissa and a leading-zero count, and rebuilds the original operand.
- Shifts the mantissa right one bit per cycle while building the matching leading-zero mask.
- Sits beside the other multi-cycle ALU units and uses the same start/busy/done handshake, so the control unit can stall on busy.

---
 rtl/clz_expand.sv | 101 ++++++++++
 1 files changed

// File: rtl/clz_expand.sv
// Multi-cycle inverse of the leading-zero counter: shifts a normalized mantissa
// right by a leading-zero count while building the matching leading-zero mask.
module clz_expand #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] mant,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mask,
  output logic             norm_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_normErr;

  logic [CNT_W-1:0] w_satCount;
  logic             w_normErr;

  // Counts beyond the operand width collapse to a full-width shift.
  assign w_satCount = (count > MaxCount) ? MaxCount : count;
  assign w_normErr  = ~mant[WIDTH-1] && (w_satCount < MaxCount);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_mask      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_normErr   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shreg     <= mant;
            r_mask      <= '0;
            r_remaining <= w_satCount;
            r_normErr   <= w_normErr;
            r_busy      <= 1'b1;
            if (w_satCount == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
          r_mask  <= {1'b1, r_mask[WIDTH-1:1]};
          // Guarded decrement: the counter never wraps below zero.
          if (r_remaining != '0) begin
            r_remaining <= r_remaining - 1'b1;
          end
          if (r_remaining <= CNT_W'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_shreg;
  assign mask     = r_mask;
  assign norm_err = r_normErr;

endmodule
